// File: rtl/score_pkg.sv
// score_pkg: shared constants, BCD digit type and carry helper for the score overlay
package score_pkg;
  localparam int DIGIT_W = 16;
  localparam int DIGIT_H = 32;
  localparam int NUM_DIGITS = 4;
  localparam int FIELD_W = 64;
  typedef logic [3:0] bcd_t;
  function automatic logic [4:0] bcd_inc(bcd_t d, logic cin);
    return (cin && d == 4'd9) ? 5'b1_0000 : {1'b0, d + bcd_t'(cin)};
  endfunction
endpackage

// File: rtl/score_digits_drawer_if.sv
// score_digits_drawer_if: pixel scan inputs and draw request/colour outputs of a drawer
interface score_digits_drawer_if;
  logic        startOfFrame;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        valuesRequest;
  logic [7:0]  valuesRGB;
  modport master(input startOfFrame, pixelX, pixelY, output valuesRequest, valuesRGB);
  modport slave(output startOfFrame, pixelX, pixelY, input valuesRequest, valuesRGB);
endinterface

// File: rtl/digit_font_rom.sv
// digit_font_rom: combinational 8x16 glyph table for decimal digits, blank above 9
module digit_font_rom
  import score_pkg::*;
(
  input  bcd_t       digit,
  input  logic [3:0] row,
  output logic [7:0] fontRow
);
  logic [127:0] glyph;
  // one 16-row glyph per digit, row 0 in the top byte
  always_comb begin
    case (digit)
      4'd0:    glyph = 128'h00007CC6C6CEDEF6E6C6C67C00000000;
      4'd1:    glyph = 128'h0000183878181818181818_7E00000000;
      4'd2:    glyph = 128'h00007CC6060C183060C0C6FE00000000;
      4'd3:    glyph = 128'h00007CC606063C060606C67C00000000;
      4'd4:    glyph = 128'h00000C1C3C6CCCFE0C0C0C1E00000000;
      4'd5:    glyph = 128'h0000FEC0C0C0FC060606C67C00000000;
      4'd6:    glyph = 128'h00003860C0C0FCC6C6C6C67C00000000;
      4'd7:    glyph = 128'h0000FEC606060C183030303000000000;
      4'd8:    glyph = 128'h00007CC6C6C67CC6C6C6C67C00000000;
      4'd9:    glyph = 128'h00007CC6C6C67E0606060C7800000000;
      default: glyph = '0;
    endcase
  end
  assign fontRow = glyph[{~row, 3'b111} -: 8];
endmodule

// File: rtl/score_digits_drawer.sv
// score_digits_drawer: BCD score accumulator rendered as a blinking 4-digit overlay
module score_digits_drawer
  import score_pkg::*;
#(
  parameter logic [10:0] TOP_X       = 11'd16,
  parameter logic [10:0] TOP_Y       = 11'd16,
  parameter logic [7:0]  DIGIT_COLOR = 8'hFF,
  parameter int          BLINK_LOG2  = 5
) (
  input  logic                 clk,
  input  logic                 resetN,
  score_digits_drawer_if.master bus,
  input  logic                 addPoints,
  input  logic [3:0]           addValue,
  input  logic                 clearScore,
  input  logic                 gameOver,
  output logic [15:0]          scoreBCD
);
  logic [15:0] score_d, score_q, disp_d, disp_q;
  logic [BLINK_LOG2:0] frame_cnt_d, frame_cnt_q;
  logic go_d, go_q, req_d, req_q;
  logic [7:0] rgb_d, rgb_q, font_row;
  bcd_t add_v, units, dig;
  logic [4:0] u_sum, t_r, h_r, th_r;
  logic u_c, in_field, visible, blank;
  logic [10:0] off_x, off_y;
  logic [1:0] idx;
  // score arithmetic, frame snapshot and blink counter
  always_comb begin
    add_v = addValue > 4'd9 ? 4'd9 : addValue;
    u_sum = {1'b0, score_q[3:0]} + {1'b0, add_v};
    u_c = u_sum > 5'd9;
    units = u_c ? 4'(u_sum - 5'd10) : u_sum[3:0];
    t_r = bcd_inc(score_q[7:4], u_c);
    h_r = bcd_inc(score_q[11:8], t_r[4]);
    th_r = bcd_inc(score_q[15:12], h_r[4]);
    score_d = clearScore ? 16'h0000 : !addPoints ? score_q :
              th_r[4] ? 16'h9999 : {th_r[3:0], h_r[3:0], t_r[3:0], units};
    disp_d = bus.startOfFrame ? score_q : disp_q;
    go_d = gameOver;
    frame_cnt_d = (gameOver && !go_q) ? '0 : bus.startOfFrame ? frame_cnt_q + 1'b1 : frame_cnt_q;
  end
  digit_font_rom u_rom (.digit(dig), .row(off_y[4:1]), .fontRow(font_row));
  // pixel hit test: field bounds, digit select, leading-zero blanking, font bit
  always_comb begin
    off_x = bus.pixelX - TOP_X;
    off_y = bus.pixelY - TOP_Y;
    in_field = bus.pixelX >= TOP_X && off_x < 11'(FIELD_W) && bus.pixelY >= TOP_Y && off_y < 11'(DIGIT_H);
    idx = off_x[5:4];
    dig = idx == 2'd0 ? disp_q[15:12] : idx == 2'd1 ? disp_q[11:8] : idx == 2'd2 ? disp_q[7:4] : disp_q[3:0];
    blank = idx == 2'd0 ? ~|disp_q[15:12] : idx == 2'd1 ? ~|disp_q[15:8] : idx == 2'd2 ? ~|disp_q[15:4] : 1'b0;
    visible = !gameOver || !frame_cnt_q[BLINK_LOG2];
    req_d = in_field && visible && !blank && font_row[3'd7 - off_x[3:1]];
    rgb_d = req_d ? DIGIT_COLOR : 8'h00;
  end
  // state and the single output register stage
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      score_q <= '0;
      disp_q <= '0;
      frame_cnt_q <= '0;
      go_q <= 1'b0;
      req_q <= 1'b0;
      rgb_q <= 8'h00;
    end else begin
      score_q <= score_d;
      disp_q <= disp_d;
      frame_cnt_q <= frame_cnt_d;
      go_q <= go_d;
      req_q <= req_d;
      rgb_q <= rgb_d;
    end
  end
  assign bus.valuesRequest = req_q;
  assign bus.valuesRGB = rgb_q;
  assign scoreBCD = score_q;
endmodule

// File: tb/tb_score_digits_drawer.sv
// tb_score_digits_drawer: directed checks of score arithmetic, rendering, blink and latency
module tb_score_digits_drawer;
  logic clk, resetN, addPoints, clearScore, gameOver;
  logic [3:0] addValue;
  logic [15:0] scoreBCD;
  int vectors = 0;
  int miscompares = 0;
  int lit_total, lit_outside;
  logic [6:0] pat;
  score_digits_drawer_if bus();
  score_digits_drawer #(.BLINK_LOG2(1)) dut (
    .clk(clk), .resetN(resetN), .bus(bus), .addPoints(addPoints), .addValue(addValue),
    .clearScore(clearScore), .gameOver(gameOver), .scoreBCD(scoreBCD)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_px(input string tag, input int x, input int y, input logic e);
    bus.pixelX = 11'(x);
    bus.pixelY = 11'(y);
    tick();
    chk(tag, 16'(bus.valuesRequest), 16'(e));
    chk({tag, "_rgb"}, 16'(bus.valuesRGB), e ? 16'h00FF : 16'h0000);
  endtask
  task automatic add_n(input logic [3:0] v, input int n);
    addPoints = 1'b1;
    addValue = v;
    repeat (n) tick();
    addPoints = 1'b0;
  endtask
  task automatic sof();
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
  endtask
  initial begin
    resetN = 1'b0;
    addPoints = 1'b0;
    addValue = 4'd0;
    clearScore = 1'b0;
    gameOver = 1'b0;
    bus.startOfFrame = 1'b0;
    bus.pixelX = 11'd0;
    bus.pixelY = 11'd0;
    repeat (2) tick();
    chk("rst_req", 16'(bus.valuesRequest), 16'h0);
    chk("rst_rgb", 16'(bus.valuesRGB), 16'h0);
    chk("rst_score", scoreBCD, 16'h0000);
    resetN = 1'b1;
    tick();
    lit_total = 0;
    lit_outside = 0;
    for (int y = 0; y < 64; y++)
      for (int x = 0; x < 96; x++) begin
        bus.pixelX = 11'(x);
        bus.pixelY = 11'(y);
        tick();
        if (bus.valuesRequest) begin
          lit_total++;
          if (x < 64 || x > 79 || y < 16 || y > 47) lit_outside++;
        end
      end
    chk("scan_lit_total", 16'(lit_total), 16'd192);
    chk("scan_lit_outside", 16'(lit_outside), 16'd0);
    chk_px("zero_row2", 66, 20, 1'b1);
    chk_px("zero_col0", 64, 22, 1'b1);
    chk_px("zero_dark", 64, 20, 1'b0);
    chk_px("zero_col6", 77, 22, 1'b1);
    chk_px("cell2_blank", 48, 22, 1'b0);
    chk_px("left_nowrap", 0, 22, 1'b0);
    chk_px("right_edge", 80, 22, 1'b0);
    chk_px("bottom_edge", 66, 52, 1'b0);
    chk_px("top_nowrap", 66, 4, 1'b0);
    add_n(4'd7, 1);
    add_n(4'd7, 1);
    chk("score_14", scoreBCD, 16'h0014);
    chk_px("pre_sof_cell2", 54, 20, 1'b0);
    chk_px("pre_sof_cell3", 66, 20, 1'b1);
    sof();
    chk_px("d14_one", 54, 20, 1'b1);
    chk_px("d14_four", 64, 30, 1'b1);
    chk_px("d14_four_r2", 66, 20, 1'b0);
    chk_px("d14_cell1_blank", 34, 20, 1'b0);
    chk_px("d14_cell0_blank", 22, 20, 1'b0);
    clearScore = 1'b1;
    tick();
    clearScore = 1'b0;
    chk("clear", scoreBCD, 16'h0000);
    add_n(4'd9, 112);
    chk("score_1008", scoreBCD, 16'h1008);
    sof();
    chk_px("d1008_cell0", 22, 20, 1'b1);
    chk_px("d1008_cell1", 34, 20, 1'b1);
    chk_px("d1008_cell2", 50, 20, 1'b1);
    chk_px("d1008_cell3", 66, 20, 1'b1);
    add_n(4'd9, 998);
    chk("score_9990", scoreBCD, 16'h9990);
    add_n(4'd5, 1);
    chk("score_9995", scoreBCD, 16'h9995);
    add_n(4'd9, 1);
    chk("sat_9999", scoreBCD, 16'h9999);
    add_n(4'd1, 1);
    chk("sat_hold", scoreBCD, 16'h9999);
    clearScore = 1'b1;
    add_n(4'd5, 1);
    clearScore = 1'b0;
    chk("clear_prio", scoreBCD, 16'h0000);
    add_n(4'hF, 1);
    chk("clamp_F", scoreBCD, 16'h0009);
    addPoints = 1'b1;
    addValue = 4'd1;
    sof();
    addPoints = 1'b0;
    chk("sof_add_score", scoreBCD, 16'h0010);
    chk_px("sof_add_old3", 64, 28, 1'b0);
    chk_px("sof_add_old2", 54, 20, 1'b0);
    sof();
    chk_px("sof_add_new3", 64, 28, 1'b1);
    chk_px("sof_add_new2", 54, 20, 1'b1);
    gameOver = 1'b1;
    tick();
    pat = 7'b0110011;
    for (int i = 0; i < 7; i++) begin
      chk_px($sformatf("blink_%0d", i), 64, 28, pat[i]);
      sof();
    end
    gameOver = 1'b0;
    chk_px("blink_off", 64, 28, 1'b1);
    bus.pixelX = 11'd0;
    bus.pixelY = 11'd0;
    tick();
    bus.pixelX = 11'd64;
    bus.pixelY = 11'd28;
    #1;
    chk("lat_hold0", 16'(bus.valuesRequest), 16'h0);
    tick();
    chk("lat_rise", 16'(bus.valuesRequest), 16'h1);
    bus.pixelX = 11'd0;
    bus.pixelY = 11'd0;
    #1;
    chk("lat_hold1", 16'(bus.valuesRequest), 16'h1);
    tick();
    chk("lat_fall", 16'(bus.valuesRequest), 16'h0);
    chk_px("pre_rst", 64, 28, 1'b1);
    #2;
    resetN = 1'b0;
    #1;
    chk("async_rst_req", 16'(bus.valuesRequest), 16'h0);
    chk("async_rst_rgb", 16'(bus.valuesRGB), 16'h0);
    chk("async_rst_score", scoreBCD, 16'h0000);
    @(negedge clk);
    resetN = 1'b1;
    tick();
    chk("post_rst_zero", 16'(bus.valuesRequest), 16'h1);
    chk_px("post_rst_cell2", 54, 20, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
